// File: rtl/bus_memtest_master.sv
// Bus memory test master: writes SEED^address to WORDS consecutive words, reads them back
// and reports pass, the first mismatching word, or a read-response timeout.
module bus_memtest_master #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned WORDS        = 1024,
    parameter logic [31:0] SEED         = 32'hA5A5_5A5A,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk_gen,
    input  logic        srst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [31:0] fail_addr_bo,
    output logic [31:0] fail_rdata_bo,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_bo,
    output logic [31:0] bus_wdata_bo,
    output logic [3:0]  bus_be_bo,
    input  logic        bus_ack_i,
    input  logic        bus_resp_i,
    input  logic [31:0] bus_rdata_bi
);

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE} state_t;

    localparam logic [16:0] LAST_IDX = 17'(WORDS - 1);
    localparam logic [15:0] TMO      = 16'(RESP_TIMEOUT);

    state_t      state, state_nxt;
    logic [16:0] idx, idx_nxt;
    logic [15:0] timer, timer_nxt;
    logic        pass_nxt, timeout_nxt;
    logic [31:0] fail_addr_nxt, fail_rdata_nxt;
    logic [31:0] cur_addr, cur_pat;

    assign cur_addr  = BASE_ADDR + {13'd0, idx, 2'b00};
    assign cur_pat   = SEED ^ cur_addr;
    assign bus_be_bo = 4'hF;

    // NOTE: non-blocking assignments so every register samples the pre-edge values together.
    always_ff @(posedge clk_gen) begin
        if (srst) begin
            state         <= IDLE;
            idx           <= '0;
            timer         <= '0;
            pass_o        <= 1'b0;
            timeout_o     <= 1'b0;
            fail_addr_bo  <= '0;
            fail_rdata_bo <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            timer         <= timer_nxt;
            pass_o        <= pass_nxt;
            timeout_o     <= timeout_nxt;
            fail_addr_bo  <= fail_addr_nxt;
            fail_rdata_bo <= fail_rdata_nxt;
        end
    end

    // Bus outputs are decoded from state and idx only, so they hold until acceptance
    // and bus_ack_i never reaches bus_req_o combinationally.
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        state_nxt      = state;
        idx_nxt        = idx;
        timer_nxt      = timer;
        pass_nxt       = pass_o;
        timeout_nxt    = timeout_o;
        fail_addr_nxt  = fail_addr_bo;
        fail_rdata_nxt = fail_rdata_bo;
        busy_o         = (state != IDLE);
        done_o         = 1'b0;
        bus_req_o      = 1'b0;
        bus_we_o       = 1'b0;
        bus_addr_bo    = '0;
        bus_wdata_bo   = '0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt      = WR_REQ;
                    idx_nxt        = '0;
                    pass_nxt       = 1'b0;
                    timeout_nxt    = 1'b0;
                    fail_addr_nxt  = '0;
                    fail_rdata_nxt = '0;
                end
            end
            WR_REQ: begin
                bus_req_o    = 1'b1;
                bus_we_o     = 1'b1;
                bus_addr_bo  = cur_addr;
                bus_wdata_bo = cur_pat;
                if (bus_ack_i) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = RD_REQ;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 17'd1;
                    end
                end
            end
            RD_REQ: begin
                bus_req_o   = 1'b1;
                bus_addr_bo = cur_addr;
                if (bus_ack_i) begin
                    state_nxt = RD_WAIT;
                    timer_nxt = '0;
                end
            end
            RD_WAIT: begin
                // A response on the timeout cycle takes priority over the timeout.
                if (bus_resp_i) begin
                    if (bus_rdata_bi != cur_pat) begin
                        fail_addr_nxt  = cur_addr;
                        fail_rdata_nxt = bus_rdata_bi;
                        pass_nxt       = 1'b0;
                        state_nxt      = DONE;
                    end else if (idx == LAST_IDX) begin
                        pass_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 17'd1;
                        state_nxt = RD_REQ;
                    end
                end else if (timer == TMO) begin
                    timeout_nxt    = 1'b1;
                    fail_addr_nxt  = cur_addr;
                    fail_rdata_nxt = '0;
                    pass_nxt       = 1'b0;
                    state_nxt      = DONE;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_memtest_master.sv
// Scoreboard bench for bus_memtest_master (WORDS=4, RESP_TIMEOUT=8): expected transfers and
// results are queued at test start and compared as the bus slave model sees them.
module tb_bus_memtest_master;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SEED = 32'hA5A5_5A5A;
    localparam int          NW   = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic        pass;
        logic        tmo;
        logic [31:0] faddr;
        logic [31:0] frdata;
    } res_t;

    logic        clk_gen, srst, start_i;
    logic        busy_o, done_o, pass_o, timeout_o;
    logic [31:0] fail_addr_bo, fail_rdata_bo;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_bo, bus_wdata_bo;
    logic [3:0]  bus_be_bo;
    logic        bus_ack_i, bus_resp_i;
    logic [31:0] bus_rdata_bi;

    bus_memtest_master #(
        .BASE_ADDR   (BASE),
        .WORDS       (NW),
        .SEED        (SEED),
        .RESP_TIMEOUT(8)
    ) dut (
        .clk_gen      (clk_gen),
        .srst         (srst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .timeout_o    (timeout_o),
        .fail_addr_bo (fail_addr_bo),
        .fail_rdata_bo(fail_rdata_bo),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_bo  (bus_addr_bo),
        .bus_wdata_bo (bus_wdata_bo),
        .bus_be_bo    (bus_be_bo),
        .bus_ack_i    (bus_ack_i),
        .bus_resp_i   (bus_resp_i),
        .bus_rdata_bi (bus_rdata_bi)
    );

    initial clk_gen = 1'b0;
    always #5 clk_gen = ~clk_gen;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    xfer_t       exp_q[$];
    res_t        res_q[$];
    logic [31:0] mem[logic [31:0]];

    // Slave model configuration and state
    bit          no_resp     = 0;
    bit          late_resp   = 0;
    bit          corrupt_on  = 0;
    bit          stall_on    = 0;
    int          stall_cnt   = 0;
    bit          rd_out      = 0;
    logic [31:0] rd_addr     = '0;
    int          rd_acc_cyc  = 0;
    int          n_rd_acc    = 0;
    int          done_cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return BASE + 32'(4 * i);
    endfunction

    // One clock: the slave decides ack/resp at the falling edge, the DUT samples at the
    // rising edge, and the caller observes outputs 1 ns later.
    task automatic step();
        xfer_t e;
        @(negedge clk_gen);
        bus_ack_i    = 1'b0;
        bus_resp_i   = 1'b0;
        bus_rdata_bi = 32'hDEAD_BEEF;
        if (srst || !busy_o) begin
            rd_out    = 0;
            stall_cnt = 0;
        end
        if (bus_req_o) check("no_req_with_read_outstanding", 32'(rd_out), 32'd0);
        if (late_resp) begin
            bus_resp_i   = 1'b1;
            bus_rdata_bi = 32'h1234_5678;
        end else if (rd_out && !no_resp) begin
            bus_resp_i   = 1'b1;
            bus_rdata_bi = (corrupt_on && rd_addr == BASE + 32'd8) ? 32'd0 :
                           (mem.exists(rd_addr) ? mem[rd_addr] : 32'd0);
            rd_out = 0;
        end
        if (bus_req_o) begin
            check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            check("req_be", 32'(bus_be_bo), 32'hF);
            if (exp_q.size() == 0) begin
                bus_ack_i = 1'b1;
            end else begin
                e = exp_q[0];
                check("req_we", 32'(bus_we_o), 32'(e.we));
                check("req_addr", bus_addr_bo, e.addr);
                check("req_wdata", bus_wdata_bo, e.wdata);
                if (stall_on && bus_we_o && bus_addr_bo == BASE + 32'd4 && stall_cnt < 5) begin
                    stall_cnt++;
                end else begin
                    bus_ack_i = 1'b1;
                    void'(exp_q.pop_front());
                    if (bus_we_o) begin
                        mem[bus_addr_bo] = bus_wdata_bo;
                    end else begin
                        rd_out     = 1;
                        rd_addr    = bus_addr_bo;
                        rd_acc_cyc = cyc + 1;
                        n_rd_acc++;
                    end
                end
            end
        end
        @(posedge clk_gen);
        cyc++;
        #1;
    endtask

    task automatic push_test(input int n_reads, input res_t r);
        for (int i = 0; i < NW; i++) exp_q.push_back('{1'b1, addr_of(i), SEED ^ addr_of(i)});
        for (int i = 0; i < n_reads; i++) exp_q.push_back('{1'b0, addr_of(i), 32'd0});
        res_q.push_back(r);
    endtask

    task automatic run_test(input string name, input bit hold_start, input int exp_cycles);
        int   cycles;
        res_t r;
        start_i = 1'b1;
        step();
        cycles = 1;
        check({name, "_busy_at_start"}, 32'(busy_o), 32'd1);
        check({name, "_pass_cleared"}, 32'(pass_o), 32'd0);
        check({name, "_timeout_cleared"}, 32'(timeout_o), 32'd0);
        check({name, "_faddr_cleared"}, fail_addr_bo, 32'd0);
        check({name, "_frdata_cleared"}, fail_rdata_bo, 32'd0);
        if (!hold_start) start_i = 1'b0;
        while (!done_o && cycles < 300) begin
            step();
            cycles++;
        end
        done_cyc = cyc;
        check({name, "_done_seen"}, 32'(done_o), 32'd1);
        check({name, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({name, "_result_expected"}, 32'(res_q.size() != 0), 32'd1);
        if (res_q.size() != 0) begin
            r = res_q.pop_front();
            check({name, "_pass"}, 32'(pass_o), 32'(r.pass));
            check({name, "_timeout"}, 32'(timeout_o), 32'(r.tmo));
            check({name, "_fail_addr"}, fail_addr_bo, r.faddr);
            check({name, "_fail_rdata"}, fail_rdata_bo, r.frdata);
        end
        check({name, "_all_xfers_seen"}, 32'(exp_q.size()), 32'd0);
        step();
        check({name, "_done_one_cycle"}, 32'(done_o), 32'd0);
        check({name, "_idle_after_done"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int guard;
        srst         = 1'b1;
        start_i      = 1'b0;
        bus_ack_i    = 1'b0;
        bus_resp_i   = 1'b0;
        bus_rdata_bi = '0;
        repeat (3) step();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_pass", 32'(pass_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_faddr", fail_addr_bo, 32'd0);
        check("rst_frdata", fail_rdata_bo, 32'd0);
        check("rst_be", 32'(bus_be_bo), 32'hF);
        srst = 1'b0;
        step();

        // Nominal pass: 4 writes, 4 reads, 12 bus-active cycles
        push_test(NW, '{1'b1, 1'b0, 32'd0, 32'd0});
        run_test("nominal", 0, 13);

        // Corrupted read at word 2 with start held high throughout
        corrupt_on = 1;
        push_test(3, '{1'b0, 1'b0, BASE + 32'd8, 32'd0});
        run_test("corrupt", 1, 11);
        check("held_pass_in_idle", 32'(pass_o), 32'd0);
        check("held_faddr_in_idle", fail_addr_bo, BASE + 32'd8);
        corrupt_on = 0;
        push_test(NW, '{1'b1, 1'b0, 32'd0, 32'd0});
        run_test("restart", 0, 13);

        // Response timeout on the first read
        no_resp = 1;
        push_test(1, '{1'b0, 1'b1, BASE, 32'd0});
        run_test("timeout", 0, 15);
        check("timeout_latency", 32'(done_cyc - rd_acc_cyc), 32'd9);
        no_resp = 0;

        // Write 1 stalled 5 cycles
        stall_on = 1;
        push_test(NW, '{1'b1, 1'b0, 32'd0, 32'd0});
        run_test("stall", 0, 18);
        check("stall_cycles_seen", 32'(stall_cnt), 32'd5);
        stall_on = 0;

        // Reset in RD_WAIT, then a late response
        no_resp  = 1;
        n_rd_acc = 0;
        for (int i = 0; i < NW; i++) exp_q.push_back('{1'b1, addr_of(i), SEED ^ addr_of(i)});
        exp_q.push_back('{1'b0, addr_of(0), 32'd0});
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        guard = 0;
        while (n_rd_acc == 0 && guard < 50) begin
            step();
            guard++;
        end
        check("reset_test_read_accepted", 32'(n_rd_acc), 32'd1);
        repeat (3) step();
        check("rdwait_busy", 32'(busy_o), 32'd1);
        check("rdwait_no_req", 32'(bus_req_o), 32'd0);
        srst = 1'b1;
        step();
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_req", 32'(bus_req_o), 32'd0);
        check("midrst_addr", bus_addr_bo, 32'd0);
        check("midrst_timeout", 32'(timeout_o), 32'd0);
        srst = 1'b0;
        exp_q.delete();
        res_q.delete();
        late_resp = 1;
        step();
        late_resp = 0;
        check("late_resp_busy", 32'(busy_o), 32'd0);
        check("late_resp_done", 32'(done_o), 32'd0);
        step();
        check("late_resp_busy2", 32'(busy_o), 32'd0);
        check("late_resp_pass", 32'(pass_o), 32'd0);
        no_resp = 0;
        push_test(NW, '{1'b1, 1'b0, 32'd0, 32'd0});
        run_test("after_reset", 0, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_memtest_master.md
BUS_MEMTEST_MASTER -- requirements
Module: bus_memtest_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h80000000, byte address of the first word tested.
REQ-002 Parameter WORDS, default 1024, number of 32-bit words tested; legal range 1..65536.
REQ-003 Parameter SEED, default 32'hA5A5_5A5A, pattern seed.
REQ-004 Parameter RESP_TIMEOUT, default 255, maximum cycles to wait for a read response; legal range 1..65535.
REQ-005 clk_gen  in  1  clock; all logic on posedge.
REQ-006 srst  in  1  reset, synchronous, active-high.
REQ-007 start_i  in  1  test start request, sampled in IDLE only.
REQ-008 busy_o  out  1  high in every state except IDLE.
REQ-009 done_o  out  1  one-cycle pulse at test completion.
REQ-010 pass_o  out  1  result of the last completed test; valid from the done_o pulse until the next start.
REQ-011 timeout_o  out  1  the last test failed on a response timeout.
REQ-012 fail_addr_bo  out  32  address of the first failing word.
REQ-013 fail_rdata_bo  out  32  data read at fail_addr_bo; 0 on timeout.
REQ-014 bus_req_o, bus_we_o  out  1 each  bus request, write enable.
REQ-015 bus_addr_bo, bus_wdata_bo  out  32 each  byte address, write data.
REQ-016 bus_be_bo  out  4  byte enables, always 4'hF.
REQ-017 bus_ack_i, bus_resp_i  in  1 each  request accepted, read data valid.
REQ-018 bus_rdata_bi  in  32  read data, valid only while bus_resp_i=1.

Function
REQ-019 Word i address A(i)=BASE_ADDR+4*i (32-bit wrap); pattern D(i)=SEED ^ A(i).
REQ-020 The FSM shall have states IDLE, WR_REQ, RD_REQ, RD_WAIT and DONE, with word index idx[16:0].
REQ-021 IDLE: if start_i=1 -> WR_REQ with idx=0, and pass_o, timeout_o, fail_addr_bo and fail_rdata_bo cleared; otherwise stay.
REQ-022 A transfer is accepted in a cycle with bus_req_o=1 and bus_ack_i=1.
REQ-023 While bus_req_o=1 and unaccepted, bus_we_o, bus_addr_bo and bus_wdata_bo shall hold stable, and bus_req_o shall not drop.
REQ-024 WR_REQ: drive req=1, we=1, addr=A(idx), wdata=D(idx); on acceptance, idx=WORDS-1 -> RD_REQ with idx=0, else idx+1.
REQ-025 Writes expect no response; bus_resp_i outside RD_WAIT shall be ignored.
REQ-026 RD_REQ: drive req=1, we=0, addr=A(idx), wdata=0; on acceptance -> RD_WAIT and response timer cleared.
REQ-027 At most one read is outstanding; no new request is issued while in RD_WAIT.
REQ-028 RD_WAIT, bus_resp_i=1 with bus_rdata_bi!=D(idx): fail_addr_bo=A(idx), fail_rdata_bo=bus_rdata_bi, pass_o=0 -> DONE.
REQ-029 RD_WAIT, bus_resp_i=1 with a match: idx=WORDS-1 -> DONE with pass_o=1, else idx+1 and -> RD_REQ.
REQ-030 RD_WAIT timer increments each cycle without a response.
REQ-031 Timeout: on the cycle the timer equals RESP_TIMEOUT with no response, set timeout_o=1, fail_addr_bo=A(idx), fail_rdata_bo=0, pass_o=0 -> DONE.
REQ-032 A response arriving on the timeout cycle wins over the timeout.
REQ-033 DONE: done_o=1 for exactly one cycle -> IDLE.
REQ-034 start_i while busy_o=1 shall be ignored; start_i in the DONE cycle shall be ignored.
REQ-035 The earliest response accepted is the cycle after read acceptance; resp-to-next-req gap is zero cycles.
REQ-036 bus_req_o=0 in IDLE, RD_WAIT and DONE; outputs shall be registered or state-decoded, with no combinational path from bus_ack_i to bus_req_o.

Reset
REQ-037 srst=1 at any clock edge -> IDLE, idx=0, timer=0, and all outputs 0 (bus_be_bo=4'hF), including mid-transfer.
REQ-038 An aborted transfer is abandoned without completion; the test restarts only on a new start_i after srst deasserts.

Verification
REQ-039 WORDS=4, always-ack slave with 1-cycle read latency, start pulse -> 4 writes to 0x80000000..0x8000000C with D=SEED^addr, then 4 reads; done_o after 12 cycles of bus activity; pass_o=1, timeout_o=0.
REQ-040 Slave corrupts the read at 0x80000008 to 0 -> pass_o=0, fail_addr_bo=0x80000008, fail_rdata_bo=0, only 3 reads issued.
REQ-041 RESP_TIMEOUT=8, slave never asserts resp -> done_o 9 cycles after read accept; timeout_o=1, fail_addr_bo=0x80000000.
REQ-042 Slave holds ack=0 for 5 cycles on write 1 -> request fields stable all 5 cycles, no duplicate write; test passes.
REQ-043 srst pulsed during RD_WAIT -> next cycle busy_o=0, bus_req_o=0; a late resp is ignored; a new start gives a clean pass.
REQ-044 start_i held high through a test -> ignored while busy and in DONE, a new test starts on the first IDLE cycle, and pass_o and fail fields clear at that start.
